// File: rtl/i2c_apb_sequencer.sv
// APB master sequencing full I2C transactions on i2c_top for two round-robin requesters.
// Latency: one APB access per >=3 cycles (gap, SETUP, ACCESS); stalls on pready_i low and on missing TX bytes.
module i2c_apb_sequencer #(
    parameter logic [7:0] PRESCALE    = 8'h06,
    parameter logic [7:0] STATUS_ADDR = 8'h08,
    parameter int         DONE_BIT    = 0,
    parameter int         NACK_BIT    = 1,
    parameter int         POLL_MAX    = 1023
) (
    input  logic        pclk_i,
    input  logic        preset_ni,
    input  logic [1:0]  req_valid_i,
    input  logic [1:0]  req_rnw_i,
    input  logic [13:0] req_addr_i,
    input  logic [5:0]  req_len_i,
    output logic [1:0]  grant_o,
    input  logic [15:0] txd_i,
    input  logic [1:0]  txd_valid_i,
    output logic [1:0]  txd_ready_o,
    output logic [7:0]  rxd_o,
    output logic [1:0]  rxd_valid_o,
    output logic [1:0]  done_o,
    output logic        err_o,
    output logic [7:0]  paddr_o,
    output logic [7:0]  pwdata_o,
    output logic        pwrite_o,
    output logic        psel_o,
    output logic        penable_o,
    input  logic [7:0]  prdata_i,
    input  logic        pready_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_TX, S_ADDR, S_PRESC, S_CMD, S_POLL, S_READ_RX, S_DONE
    } state_t;
    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

    localparam logic [9:0] POLL_LAST = 10'(POLL_MAX - 1);

    state_t      state_q, state_d;
    phase_t      ph_q, ph_d;
    logic        gnt_q, gnt_d, rr_q, rr_d, rnw_q, rnw_d, err_flag_q, err_flag_d;
    logic [6:0]  addr_q, addr_d;
    logic [2:0]  len_q, len_d, cnt_q, cnt_d;
    logic [9:0]  poll_q, poll_d;
    logic [1:0]  grant_q, grant_d, txd_ready_q, txd_ready_d, rxd_valid_q, rxd_valid_d, done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  rxd_q, rxd_d, paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;

    logic        start, st_write, acc_done, req_sel;
    logic [7:0]  st_addr, st_data;

    always_comb begin
        state_d = state_q;     ph_d = ph_q;         gnt_d = gnt_q;       rr_d = rr_q;
        rnw_d = rnw_q;         addr_d = addr_q;     len_d = len_q;       cnt_d = cnt_q;
        poll_d = poll_q;       err_flag_d = err_flag_q;                  rxd_d = rxd_q;
        grant_d = 2'b00;       txd_ready_d = 2'b00; rxd_valid_d = 2'b00; done_d = 2'b00;
        err_d = 1'b0;
        psel_d = psel_q;       penable_d = penable_q;                    pwrite_d = pwrite_q;
        paddr_d = paddr_q;     pwdata_d = pwdata_q;
        start = 1'b0;          st_write = 1'b0;     st_addr = 8'h00;     st_data = 8'h00;
        acc_done = (ph_q == PH_ACCESS) && pready_i;
        // With both requesting, rr_q names the one not granted last.
        req_sel = (req_valid_i == 2'b11) ? rr_q : req_valid_i[1];

        case (state_q)
            S_IDLE: begin
                if (|req_valid_i) begin
                    gnt_d      = req_sel;
                    rr_d       = ~req_sel;
                    rnw_d      = req_rnw_i[req_sel];
                    addr_d     = req_sel ? req_addr_i[13:7] : req_addr_i[6:0];
                    len_d      = req_sel ? req_len_i[5:3] : req_len_i[2:0];
                    grant_d    = req_sel ? 2'b10 : 2'b01;
                    cnt_d      = 3'd0;
                    poll_d     = 10'd0;
                    err_flag_d = 1'b0;
                    state_d    = req_rnw_i[req_sel] ? S_ADDR : S_LOAD_TX;
                end
            end
            S_LOAD_TX: begin
                if (ph_q == PH_IDLE) begin
                    if (txd_ready_q[gnt_q] && txd_valid_i[gnt_q]) begin
                        start    = 1'b1;
                        st_write = 1'b1;
                        st_addr  = 8'h00;
                        st_data  = gnt_q ? txd_i[15:8] : txd_i[7:0];
                    end else begin
                        txd_ready_d[gnt_q] = 1'b1;
                    end
                end else if (acc_done) begin
                    if (cnt_q == len_q) begin
                        cnt_d   = 3'd0;
                        state_d = S_ADDR;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_ADDR: begin
                if (ph_q == PH_IDLE) begin
                    start = 1'b1; st_write = 1'b1; st_addr = 8'h0c; st_data = {addr_q, rnw_q};
                end else if (acc_done) begin
                    state_d = S_PRESC;
                end
            end
            S_PRESC: begin
                if (ph_q == PH_IDLE) begin
                    start = 1'b1; st_write = 1'b1; st_addr = 8'h14; st_data = PRESCALE;
                end else if (acc_done) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (ph_q == PH_IDLE) begin
                    start = 1'b1; st_write = 1'b1; st_addr = 8'h10; st_data = 8'hC0;
                end else if (acc_done) begin
                    state_d = S_POLL;
                end
            end
            S_POLL: begin
                if (ph_q == PH_IDLE) begin
                    start = 1'b1; st_addr = STATUS_ADDR;
                end else if (acc_done) begin
                    if (prdata_i[DONE_BIT]) begin
                        if (prdata_i[NACK_BIT]) begin
                            err_flag_d = 1'b1;
                            state_d    = S_DONE;
                        end else begin
                            state_d = rnw_q ? S_READ_RX : S_DONE;
                        end
                    end else if (poll_q == POLL_LAST) begin
                        err_flag_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        poll_d = poll_q + 10'd1;
                    end
                end
            end
            S_READ_RX: begin
                if (ph_q == PH_IDLE) begin
                    start = 1'b1; st_addr = 8'h04;
                end else if (acc_done) begin
                    rxd_d              = prdata_i;
                    rxd_valid_d[gnt_q] = 1'b1;
                    if (cnt_q == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_DONE: begin
                done_d[gnt_q] = 1'b1;
                err_d         = err_flag_q;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Completion always returns psel low for a cycle before the next SETUP.
        if (start) begin
            psel_d = 1'b1; penable_d = 1'b0; pwrite_d = st_write;
            paddr_d = st_addr; pwdata_d = st_data; ph_d = PH_SETUP;
        end else if (ph_q == PH_SETUP) begin
            penable_d = 1'b1; ph_d = PH_ACCESS;
        end else if (acc_done) begin
            psel_d = 1'b0; penable_d = 1'b0; ph_d = PH_IDLE;
        end
    end

    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            state_q <= S_IDLE;  ph_q <= PH_IDLE;  gnt_q <= 1'b0;  rr_q <= 1'b0;
            rnw_q <= 1'b0;      addr_q <= 7'd0;   len_q <= 3'd0;  cnt_q <= 3'd0;
            poll_q <= 10'd0;    err_flag_q <= 1'b0;               rxd_q <= 8'h00;
            grant_q <= 2'b00;   txd_ready_q <= 2'b00;             rxd_valid_q <= 2'b00;
            done_q <= 2'b00;    err_q <= 1'b0;    psel_q <= 1'b0; penable_q <= 1'b0;
            pwrite_q <= 1'b0;   paddr_q <= 8'h00; pwdata_q <= 8'h00;
        end else begin
            state_q <= state_d; ph_q <= ph_d;     gnt_q <= gnt_d; rr_q <= rr_d;
            rnw_q <= rnw_d;     addr_q <= addr_d; len_q <= len_d; cnt_q <= cnt_d;
            poll_q <= poll_d;   err_flag_q <= err_flag_d;         rxd_q <= rxd_d;
            grant_q <= grant_d; txd_ready_q <= txd_ready_d;       rxd_valid_q <= rxd_valid_d;
            done_q <= done_d;   err_q <= err_d;   psel_q <= psel_d; penable_q <= penable_d;
            pwrite_q <= pwrite_d; paddr_q <= paddr_d; pwdata_q <= pwdata_d;
        end
    end

    assign grant_o     = grant_q;
    assign txd_ready_o = txd_ready_q;
    assign rxd_o       = rxd_q;
    assign rxd_valid_o = rxd_valid_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign pwrite_o    = pwrite_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;

endmodule
